// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU accumulate stage.
// Ports: none (package only).
// Provides the operation encoding and signed saturation limit helpers.
package alu_pkg;

  // Operation select carried alongside each beat.
  typedef enum logic [1:0] {
    OP_PASS_A = 2'd0,
    OP_ADD    = 2'd1,
    OP_SUB    = 2'd2,
    OP_MAC    = 2'd3
  } alu_acc_op_e;

  // Largest signed value representable in w bits, as a 64-bit pattern.
  // Callers slice the low w bits.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative signed value in w bits; the low w bits are 1000...0.
  function automatic logic [63:0] sat_min(input int unsigned w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/sfixed_sat.sv
// Signed saturating narrower: IN_W-bit two's complement in, OUT_W-bit out.
// Latency: combinational. Backpressure: none (pure function of din).
// Ports: din (IN_W, signed), dout (OUT_W, clamped), clip (1 when clamped).
module sfixed_sat
  import alu_pkg::*;
#(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             clip
);

  localparam logic [63:0]      MAX_64 = sat_max(OUT_W);
  localparam logic [63:0]      MIN_64 = sat_min(OUT_W);
  localparam logic [OUT_W-1:0] MAX_V  = MAX_64[OUT_W-1:0];
  localparam logic [OUT_W-1:0] MIN_V  = MIN_64[OUT_W-1:0];

  // The value fits in OUT_W bits exactly when every bit from the output
  // sign position upward is a copy of the input sign.
  logic [IN_W-OUT_W:0] upper;
  assign upper = din[IN_W-1:OUT_W-1];

  always_comb begin
    clip = !((&upper) || !(|upper));
    dout = din[OUT_W-1:0];
    if (clip) begin
      dout = din[IN_W-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/alu_accum_stage.sv
// Combines two signed products (pass/add/sub/MAC), saturates, outputs via valid/ready.
// Latency: 2 clock edges from accept to out_valid when not stalled.
// Backpressure: full; in_ready is combinational and drops only when S1 is full and S2 is held.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - upstream handshake for op, acc_clr, mult_a, mult_b
//   op, acc_clr          - operation select, accumulator clear (taken with the beat)
//   mult_a, mult_b       - signed BUS_WIDTH products
//   out_valid / out_ready- downstream handshake for result, sat_flag
//   result, sat_flag     - saturated result and clip indication
module alu_accum_stage
  import alu_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned FRAC_BITS = 7,
  parameter int unsigned ACC_GUARD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic                 acc_clr,
  input  logic [BUS_WIDTH-1:0] mult_a,
  input  logic [BUS_WIDTH-1:0] mult_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 sat_flag
);

  // S1 holds the exact a+/-b, one bit wider than the bus.
  localparam int unsigned S1_W  = BUS_WIDTH + 1;
  localparam int unsigned ACC_W = BUS_WIDTH + ACC_GUARD;
  // MAC sum before clamping back to the accumulator width.
  localparam int unsigned SUM_W = ACC_W + 1;

  // FRAC_BITS only documents the binary point; the datapath is scale-free.
  // Reject parameter sets that cannot describe a sensible fixed-point format.
  if (FRAC_BITS >= BUS_WIDTH) begin : g_bad_frac
    $error("alu_accum_stage: FRAC_BITS must be smaller than BUS_WIDTH");
  end
  if (ACC_GUARD < 1) begin : g_bad_guard
    $error("alu_accum_stage: ACC_GUARD must be at least 1");
  end

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  logic                 s1_valid_q, s1_valid_d;
  alu_acc_op_e          s1_op_q,    s1_op_d;
  logic                 s1_clr_q,   s1_clr_d;
  logic [S1_W-1:0]      s1_val_q,   s1_val_d;

  logic                 out_valid_q, out_valid_d;
  logic [BUS_WIDTH-1:0] result_q,    result_d;
  logic                 sat_q,       sat_d;

  logic [ACC_W-1:0]     acc_q,       acc_d;

  // ---------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------
  logic s2_free;
  logic accept;
  logic advance;

  assign s2_free  = !out_valid_q || out_ready;
  // Gated by rst_n so upstream never sees ready while reset is asserted.
  assign in_ready = rst_n && (!s1_valid_q || s2_free);
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid_q && s2_free;

  // ---------------------------------------------------------------
  // S1 datapath: exact sign-extended combine of the two products
  // ---------------------------------------------------------------
  logic [S1_W-1:0] a_ext;
  logic [S1_W-1:0] b_ext;
  logic [S1_W-1:0] s1_calc;

  assign a_ext = {mult_a[BUS_WIDTH-1], mult_a};
  assign b_ext = {mult_b[BUS_WIDTH-1], mult_b};

  always_comb begin
    s1_calc = a_ext + b_ext;
    case (alu_acc_op_e'(op))
      OP_PASS_A: s1_calc = a_ext;
      OP_SUB:    s1_calc = a_ext - b_ext;
      default:   s1_calc = a_ext + b_ext;
    endcase
  end

  // ---------------------------------------------------------------
  // S2 datapath: accumulate with guard clamp, then narrow to bus width
  // ---------------------------------------------------------------
  logic [ACC_W-1:0] acc_base;
  logic [SUM_W-1:0] mac_sum;
  logic [ACC_W-1:0] acc_next;
  logic             acc_clip;
  logic [ACC_W-1:0] res_wide;
  logic [BUS_WIDTH-1:0] res_sat;
  logic             res_clip;
  logic             s1_is_mac;

  assign s1_is_mac = (s1_op_q == OP_MAC);

  always_comb begin
    acc_base = s1_clr_q ? '0 : acc_q;
    mac_sum  = SUM_W'($signed(acc_base)) + SUM_W'($signed(s1_val_q));
  end

  sfixed_sat #(
    .IN_W  (SUM_W),
    .OUT_W (ACC_W)
  ) u_acc_sat (
    .din  (mac_sum),
    .dout (acc_next),
    .clip (acc_clip)
  );

  // Non-MAC values are widened to the accumulator width so one narrower
  // serves both paths.
  always_comb begin
    res_wide = ACC_W'($signed(s1_val_q));
    if (s1_is_mac) begin
      res_wide = acc_next;
    end
  end

  sfixed_sat #(
    .IN_W  (ACC_W),
    .OUT_W (BUS_WIDTH)
  ) u_res_sat (
    .din  (res_wide),
    .dout (res_sat),
    .clip (res_clip)
  );

  // ---------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_clr_d   = s1_clr_q;
    s1_val_d   = s1_val_q;

    // A same-cycle accept reloads S1 even while its old contents advance.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = alu_acc_op_e'(op);
      s1_clr_d   = acc_clr;
      s1_val_d   = s1_calc;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sat_d       = sat_q;
    acc_d       = acc_q;

    if (advance) begin
      // Replaces any result consumed this same cycle, so no bubble.
      out_valid_d = 1'b1;
      result_d    = res_sat;
      sat_d       = res_clip || (s1_is_mac && acc_clip);
      if (s1_is_mac) begin
        acc_d = acc_next;
      end else if (s1_clr_q) begin
        acc_d = '0;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_PASS_A;
      s1_clr_q    <= 1'b0;
      s1_val_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_clr_q    <= s1_clr_d;
      s1_val_q    <= s1_val_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat_flag  = sat_q;

endmodule

// File: doc/alu_accum_stage.md
Name: alu_accum_stage

Overview:
- Sits directly downstream of the ALU multiply stage and consumes its two signed fixed-point products (mult_a, mult_b).
- Combines them as pass, add, subtract or multiply-accumulate, saturates to bus width, and presents the result through a valid/ready output.
- Two-stage pipeline with full backpressure; holds a guarded internal accumulator for MAC chains.

Parameters:
- BUS_WIDTH, 8, width of products and result; signed two's complement.
- FRAC_BITS, 7, fractional bits of operands and result (Q0.7 at default); informational only, no rescaling is performed.
- ACC_GUARD, 4, extra integer guard bits in the accumulator; accumulator width = BUS_WIDTH+ACC_GUARD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operands and op are valid.
- in_ready  output  1  stage accepts this cycle.
- op  input  2  operation: 0 PASS_A, 1 ADD, 2 SUB, 3 MAC.
- acc_clr  input  1  clear the accumulator; sampled only with an accepted beat.
- mult_a  input  BUS_WIDTH  signed product A.
- mult_b  input  BUS_WIDTH  signed product B.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- result  output  BUS_WIDTH  saturated signed result.
- sat_flag  output  1  result was clipped; qualified by out_valid.

Behaviour:
- Reset, asynchronous, while rst_n is low:
  - s1_valid=0, out_valid=0, result=0, sat_flag=0, accumulator=0.
  - in_ready is forced to 0.
  - Reset mid-operation discards all in-flight beats and the accumulator.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - out_valid, result and sat_flag hold stable until consumed.
- Stage S1, on accept:
  - Register op and acc_clr.
  - Register the (BUS_WIDTH+1)-bit sign-extended value: a (PASS_A), a+b (ADD/MAC) or a−b (SUB).
  - Set s1_valid.
- Advance condition: s2_free = !out_valid || out_ready.
  - S1 moves to S2 when s1_valid && s2_free.
  - s1_valid clears if no new beat is accepted in the same cycle.
- in_ready = rst_n && (!s1_valid || s2_free). This is combinational; full throughput is 1 beat/cycle while out_ready=1.
- Stage S2, on advance:
  - PASS_A, ADD, SUB: result = sat(s1 value to BUS_WIDTH).
  - MAC: base = acc_clr ? 0 : acc.
    - acc_next = sat(base + s1 value to BUS_WIDTH+ACC_GUARD); acc <= acc_next.
    - result = sat(acc_next to BUS_WIDTH).
  - Non-MAC ops with acc_clr=1 set acc <= 0. Non-MAC ops with acc_clr=0 leave acc unchanged.
  - sat_flag=1 iff clipping occurred at either narrowing (BUS_WIDTH result or accumulator guard limit).
- Saturation limits:
  - BUS_WIDTH: max 2^(BUS_WIDTH−1)−1, min −2^(BUS_WIDTH−1) (0x7F/0x80 at default).
  - Accumulator limits are analogous at BUS_WIDTH+ACC_GUARD (2047/−2048 at default).
- Latency: 2 clock edges from accept to out_valid, with no stalls.
- Simultaneous events:
  - Consume and advance in the same cycle: the new result replaces the old one, with no bubble.
  - Accept and advance in the same cycle: S1 reloads.
- Accumulator state changes only on MAC advance or acc_clr advance, never on stall.

Decomposition:
- Shared package alu_pkg holds:
  - enum alu_acc_op_e {OP_PASS_A, OP_ADD, OP_SUB, OP_MAC}.
  - Localparam helpers for signed max/min at a given width.
- One natural sub-module: sfixed_sat, a parameterised combinational IN_W→OUT_W signed saturating narrower with a clip flag. It is instantiated twice (accumulator and result).

Test Plan:
- ADD, a=0x40, b=0x30, out_ready=1 → result=0x70, sat_flag=0, out_valid exactly 2 cycles after accept.
- Saturation:
  - ADD 0x60+0x60 → 0x7F with sat_flag=1.
  - SUB 0x80−0x01 → 0x80 with sat_flag=1.
  - PASS_A 0x85 → 0x85 with sat_flag=0.
- MAC chain, acc_clr on the first beat, 5 beats:
  - Beats 1–4 are a=0x20, b=0x20. Results are 0x40 (sat 0), then 0x7F (sat 1) three times; the internal accumulator reaches 0x100.
  - Beat 5 is a=0x80, b=0x80. Result is 0x00 with sat_flag=0, proving the guard bits.
- Backpressure:
  - out_ready=0 for 5 cycles while 4 beats are offered back-to-back → in_ready drops after 2 accepts.
  - On release, all 4 results appear in order, each once, with no loss and no duplication.
  - Result stays stable while stalled.
- acc_clr coincident with a MAC beat, with acc=0x50 and a=0x10, b=0x08 → result=0x18; accumulator=0x18.
- Reset mid-operation:
  - Pull rst_n low with S1 and S2 full and acc≠0 → out_valid and in_ready fall immediately (asynchronously).
  - After release, MAC 0x10+0x10 → 0x20, confirming the accumulator cleared.
